// File: rtl/alu_reg_sequencer.sv
// Operand sequencer and register bank feeding a combinational ALU: fetches two
// registers, presents them with the opcode, captures the result and writes it back.
module alu_reg_sequencer #(
  parameter int word_size = 32,
  parameter int ADDR_W    = 3,
  parameter int OP_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [ADDR_W-1:0]    cmd_rs1,
  input  logic [ADDR_W-1:0]    cmd_rs2,
  input  logic [ADDR_W-1:0]    cmd_rd,
  input  logic                 ld_en,
  input  logic [ADDR_W-1:0]    ld_addr,
  input  logic [word_size-1:0] ld_data,
  output logic [word_size-1:0] alu_a,
  output logic [word_size-1:0] alu_b,
  output logic [OP_W-1:0]      alu_op,
  input  logic [word_size-1:0] alu_result,
  output logic                 done,
  output logic [word_size-1:0] result,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [word_size-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t               state, state_nxt;
  logic [OP_W-1:0]      op_q;
  logic [ADDR_W-1:0]    rs1_q, rs2_q, rd_q;
  logic [word_size-1:0] bank [2**ADDR_W];
  logic                 accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = reset_n;
        if (cmd_valid && reset_n) state_nxt = FETCH;
      end
      FETCH: state_nxt = EXEC;
      EXEC:  state_nxt = WB;
      WB: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = cmd_valid && cmd_ready;
  assign dbg_data = bank[dbg_addr];

  // The ALU operand registers double as the fetch registers, so they hold their
  // value after EXEC; result doubles as the captured ALU result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        rd_q  <= cmd_rd;
      end
      if (state == FETCH) begin
        alu_a  <= bank[rs1_q];
        alu_b  <= bank[rs2_q];
        alu_op <= op_q;
      end
      if (state == EXEC) result <= alu_result;
    end
  end

  // Host loads only land in IDLE, so they never collide with write-back; a load
  // accompanying an accept commits before FETCH reads the bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2**ADDR_W; i++) bank[i] <= '0;
    end else if (state == IDLE && ld_en) begin
      bank[ld_addr] <= ld_data;
    end else if (state == WB) begin
      bank[rd_q] <= result;
    end
  end

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Scoreboard bench for alu_reg_sequencer: commands push expected results, a
// monitor pops and compares on every done pulse.
module tb_alu_reg_sequencer;

  localparam int W  = 32;
  localparam int AW = 3;
  localparam int OW = 3;
  localparam logic [OW-1:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_NOT = 3'd2, OP_ADD = 3'd3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [OW-1:0] cmd_op = '0;
  logic [AW-1:0] cmd_rs1 = '0, cmd_rs2 = '0, cmd_rd = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_data = '0;
  logic [W-1:0]  alu_a, alu_b, alu_result, result, dbg_data;
  logic [OW-1:0] alu_op;
  logic          done;
  logic [AW-1:0] dbg_addr = '0;

  int tests = 0;
  int failed = 0;
  int done_count = 0;
  logic [W-1:0] exp_q[$];

  alu_reg_sequencer #(.word_size(W), .ADDR_W(AW), .OP_W(OW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .done(done), .result(result), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Reference ALU attached to the operand interface
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_NOT:  alu_result = ~alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_count++;
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check("wb_result", result, exp_q.pop_front());
    end
  end

  task automatic check_reg(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // Issues one command from IDLE; returns just after the accepting edge.
  task automatic send(input logic [OW-1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                      input logic [AW-1:0] rd, input logic [W-1:0] exp, input bit track);
    wait_idle();
    cmd_valid = 1'b1; cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    @(posedge clk);
    if (track) exp_q.push_back(exp);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    int low;
    int dc;

    // Reset held for three cycles
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_bank", AW'(i), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // NOT path with latency and EXEC operand checks
    load(3'd2, 32'h0F0F_0F0F);
    send(OP_NOT, 3'd0, 3'd2, 3'd3, 32'hF0F0_F0F0, 1'b1);
    @(negedge clk);
    check("fetch_not_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("exec_alu_b", alu_b, 32'h0F0F_0F0F);
    check("exec_alu_op", {29'd0, alu_op}, {29'd0, OP_NOT});
    @(negedge clk);
    check("latency_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_reg("not_r3", 3'd3, 32'hF0F0_F0F0);
    check("alu_b_held", alu_b, 32'h0F0F_0F0F);

    // Back-to-back: cmd_valid held across two commands
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rs1 = 3'd2; cmd_rs2 = 3'd3; cmd_rd = 3'd0;
    @(posedge clk);
    exp_q.push_back(32'hFFFF_FFFF);
    low = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) break;
      low++;
    end
    check("b2b_ready_low", 32'(low), 32'd3);
    cmd_op = OP_AND; cmd_rs1 = 3'd0; cmd_rs2 = 3'd2; cmd_rd = 3'd7;
    @(posedge clk);
    exp_q.push_back(32'h0F0F_0F0F);
    #1 cmd_valid = 1'b0;
    wait_idle();
    check_reg("b2b_r0", 3'd0, 32'hFFFF_FFFF);
    check_reg("b2b_r7", 3'd7, 32'h0F0F_0F0F);

    // Dependency through write-back
    load(3'd1, 32'h0000_00F0);
    send(OP_AND, 3'd1, 3'd1, 3'd1, 32'h0000_00F0, 1'b1);
    send(OP_NOT, 3'd0, 3'd1, 3'd4, 32'hFFFF_FF0F, 1'b1);
    wait_idle();
    check_reg("dep_r4", 3'd4, 32'hFFFF_FF0F);

    // Load during EXEC is dropped; in IDLE it lands
    send(OP_OR, 3'd1, 3'd1, 3'd0, 32'h0000_00F0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 32'h0000_1234;
    @(negedge clk);
    ld_en = 1'b0;
    wait_idle();
    check_reg("busy_ld_r5", 3'd5, 32'd0);
    load(3'd5, 32'h0000_1234);
    check_reg("idle_ld_r5", 3'd5, 32'h0000_1234);

    // Load coinciding with accept is seen by FETCH
    wait_idle();
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 32'h0000_0055;
    cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rs1 = 3'd6; cmd_rs2 = 3'd6; cmd_rd = 3'd2;
    @(posedge clk);
    exp_q.push_back(32'h0000_00AA);
    #1 cmd_valid = 1'b0; ld_en = 1'b0;
    wait_idle();
    check_reg("ld_accept_r2", 3'd2, 32'h0000_00AA);

    // Reset during EXEC aborts the command
    load(3'd6, 32'h0000_AAAA);
    send(OP_ADD, 3'd6, 3'd0, 3'd6, 32'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    dc = done_count;
    reset_n = 1'b0;
    #1;
    check("abort_done_low", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_count), 32'(dc));
    check("abort_idle", {31'd0, cmd_ready}, 32'd1);
    check_reg("abort_r6", 3'd6, 32'd0);
    check_reg("abort_r5", 3'd5, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
